// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, control-bit positions and
// the occupancy encoding used by every elastic stage.
package pipe_pkg;

    localparam int XLEN          = 32;
    localparam int DEF_REG_W     = 5;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready entry bus between pipeline stages: payload, destination
// register index and control bits.
interface pipe_stage_elastic_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int REG_W  = DEF_REG_W,
    parameter int CTRL_W = 2
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] payload;
    logic [REG_W-1:0]  dest;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output payload, output dest, output ctrl, input ready);
    modport slave  (input valid, input payload, input dest, input ctrl, output ready);
endinterface

// File: rtl/pipe_skid_entry.sv
// One stage entry: valid flag plus payload/dest/ctrl, with load and clear.
// Clear wins over load so a flush always empties the entry.
module pipe_skid_entry #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d_payload,
    input  logic [REG_W-1:0]  d_dest,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              vld,
    output logic [DATA_W-1:0] payload,
    output logic [REG_W-1:0]  dest,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld     <= 1'b0;
            payload <= '0;
            dest    <= '0;
            ctrl    <= '0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load) begin
            vld     <= 1'b1;
            payload <= d_payload;
            dest    <= d_dest;
            ctrl    <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with optional skid entry, flush and a
// forwarding-hit compare on the head entry.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int REG_W  = DEF_REG_W,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_elastic_if.slave  up,
    pipe_stage_elastic_if.master dn,
    input  logic [REG_W-1:0]     fwd_src,
    output logic                 fwd_hit,
    output logic [1:0]           occupancy
);

    logic              accept, emit;
    logic              main_vld, main_ld, main_clr;
    logic [DATA_W-1:0] main_payload, main_d_payload;
    logic [REG_W-1:0]  main_dest, main_d_dest;
    logic [CTRL_W-1:0] main_ctrl, main_d_ctrl;
    logic              skid_vld, skid_ld, skid_clr;
    logic [DATA_W-1:0] skid_payload;
    logic [REG_W-1:0]  skid_dest;
    logic [CTRL_W-1:0] skid_ctrl;

    assign accept = up.valid & up.ready;
    assign emit   = main_vld & dn.ready;

    // Head is refilled from the skid entry first so ordering stays FIFO.
    always_comb begin
        main_ld        = 1'b0;
        main_clr       = flush;
        skid_ld        = 1'b0;
        skid_clr       = flush;
        main_d_payload = skid_vld ? skid_payload : up.payload;
        main_d_dest    = skid_vld ? skid_dest    : up.dest;
        main_d_ctrl    = skid_vld ? skid_ctrl    : up.ctrl;
        if (!main_vld) begin
            main_ld = accept;
        end else if (emit) begin
            if (skid_vld) begin
                main_ld  = 1'b1;
                skid_clr = 1'b1;
            end else if (accept) begin
                main_ld = 1'b1;
            end else begin
                main_clr = 1'b1;
            end
        end else if (accept) begin
            skid_ld = 1'b1;
        end
    end

    pipe_skid_entry #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) u_main (
        .clk       (clk),
        .reset     (reset),
        .clear     (main_clr),
        .load      (main_ld),
        .d_payload (main_d_payload),
        .d_dest    (main_d_dest),
        .d_ctrl    (main_d_ctrl),
        .vld       (main_vld),
        .payload   (main_payload),
        .dest      (main_dest),
        .ctrl      (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_entry #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) u_skid (
                .clk       (clk),
                .reset     (reset),
                .clear     (skid_clr),
                .load      (skid_ld),
                .d_payload (up.payload),
                .d_dest    (up.dest),
                .d_ctrl    (up.ctrl),
                .vld       (skid_vld),
                .payload   (skid_payload),
                .dest      (skid_dest),
                .ctrl      (skid_ctrl)
            );
            // Registered ready: downstream ready never reaches upstream combinationally.
            assign up.ready = !skid_vld;
        end else begin : g_single
            assign skid_vld     = 1'b0;
            assign skid_payload = '0;
            assign skid_dest    = '0;
            assign skid_ctrl    = '0;
            assign up.ready     = !main_vld | dn.ready;
        end
    endgenerate

    assign dn.valid   = main_vld;
    assign dn.payload = main_payload;
    assign dn.dest    = main_vld ? main_dest : '0;
    assign dn.ctrl    = main_vld ? main_ctrl : '0;
    assign occupancy  = occ_count(main_vld, skid_vld);

    // Only the head can forward; a younger skid entry is deliberately ignored.
    assign fwd_hit = main_vld & main_ctrl[CTRL_REGWRITE] &
                     (main_dest == fwd_src) & (fwd_src != '0);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: table-driven vectors on the skid build,
// streaming and scoreboard ordering, plus the combinational-ready build.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [4:0] fwd_src = '0;
    logic       fwd_hit1, fwd_hit0;
    logic [1:0] occ1, occ0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_emit  = 0;

    pipe_stage_elastic_if #(.DATA_W(32), .REG_W(5), .CTRL_W(2)) u1 ();
    pipe_stage_elastic_if #(.DATA_W(32), .REG_W(5), .CTRL_W(2)) d1 ();
    pipe_stage_elastic_if #(.DATA_W(32), .REG_W(5), .CTRL_W(2)) u0 ();
    pipe_stage_elastic_if #(.DATA_W(32), .REG_W(5), .CTRL_W(2)) d0 ();

    pipe_stage_elastic #(.DATA_W(32), .REG_W(5), .CTRL_W(2), .SKID(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .up(u1.slave), .dn(d1.master),
        .fwd_src(fwd_src), .fwd_hit(fwd_hit1), .occupancy(occ1));

    pipe_stage_elastic #(.DATA_W(32), .REG_W(5), .CTRL_W(2), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .up(u0.slave), .dn(d0.master),
        .fwd_src(fwd_src), .fwd_hit(fwd_hit0), .occupancy(occ0));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pl;
        logic [4:0]  dst;
        logic [1:0]  ctl;
    } ent_t;

    ent_t sb[$];
    ent_t exp_e;

    // Scoreboard on the skid build: pushes on accept, pops on emit.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (d1.valid && d1.ready) begin
                n_emit++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h expected none", d1.payload);
                end else begin
                    exp_e = sb.pop_front();
                    chk("sb_payload", d1.payload, exp_e.pl);
                    chk("sb_dest", {27'd0, d1.dest}, {27'd0, exp_e.dst});
                    chk("sb_ctrl", {30'd0, d1.ctrl}, {30'd0, exp_e.ctl});
                end
            end
            if (flush) sb.delete();
            else if (u1.valid && u1.ready) sb.push_back('{u1.payload, u1.dest, u1.ctrl});
        end
    end

    typedef struct {
        logic        rst, fl, iv, orr;
        logic [31:0] pl;
        logic [4:0]  dst;
        logic [1:0]  ctl;
        logic [4:0]  fs;
        logic        e_ov, e_ir;
        logic [1:0]  e_occ;
        logic        e_hit;
        logic [4:0]  e_dst;
        logic [1:0]  e_ctl;
        logic [31:0] e_pl;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv, input logic orr,
                                input logic [31:0] pl, input logic [4:0] dst, input logic [1:0] ctl,
                                input logic [4:0] fs, input logic e_ov, input logic e_ir,
                                input logic [1:0] e_occ, input logic e_hit, input logic [4:0] e_dst,
                                input logic [1:0] e_ctl, input logic [31:0] e_pl);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.orr = orr;
        v.pl = pl; v.dst = dst; v.ctl = ctl; v.fs = fs;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_hit = e_hit;
        v.e_dst = e_dst; v.e_ctl = e_ctl; v.e_pl = e_pl;
        return v;
    endfunction

    task automatic apply(input int idx, input vec_t v);
        string tag;
        reset      = v.rst;
        flush      = v.fl;
        u1.valid   = v.iv;
        u1.payload = v.pl;
        u1.dest    = v.dst;
        u1.ctrl    = v.ctl;
        d1.ready   = v.orr;
        fwd_src    = v.fs;
        @(posedge clk);
        #1;
        tag = $sformatf("row%0d", idx);
        chk({tag, "_out_valid"}, {31'd0, d1.valid}, {31'd0, v.e_ov});
        chk({tag, "_in_ready"}, {31'd0, u1.ready}, {31'd0, v.e_ir});
        chk({tag, "_occupancy"}, {30'd0, occ1}, {30'd0, v.e_occ});
        chk({tag, "_fwd_hit"}, {31'd0, fwd_hit1}, {31'd0, v.e_hit});
        chk({tag, "_out_dest"}, {27'd0, d1.dest}, {27'd0, v.e_dst});
        chk({tag, "_out_ctrl"}, {30'd0, d1.ctrl}, {30'd0, v.e_ctl});
        chk({tag, "_out_payload"}, d1.payload, v.e_pl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int emit_base;
        u1.valid = 1'b0; u1.payload = '0; u1.dest = '0; u1.ctrl = '0; d1.ready = 1'b0;
        u0.valid = 1'b0; u0.payload = '0; u0.dest = '0; u0.ctrl = '0; d0.ready = 1'b0;

        //              rst fl iv or  pl     dst ctl fs   ov ir occ hit dst ctl pl
        vecs[0]  = mk(1, 0, 1, 0, 32'h55, 3,  1, 3,  0, 1, 0, 0, 0,  0, 32'h0);
        vecs[1]  = mk(0, 0, 1, 0, 32'h0A, 7,  1, 7,  1, 1, 1, 1, 7,  1, 32'h0A);
        vecs[2]  = mk(0, 0, 1, 0, 32'h0B, 9,  1, 7,  1, 0, 2, 1, 7,  1, 32'h0A);
        vecs[3]  = mk(0, 0, 1, 0, 32'h0D, 4,  1, 9,  1, 0, 2, 0, 7,  1, 32'h0A);
        vecs[4]  = mk(0, 0, 0, 0, 32'h00, 0,  0, 0,  1, 0, 2, 0, 7,  1, 32'h0A);
        vecs[5]  = mk(0, 0, 0, 1, 32'h00, 0,  0, 7,  1, 1, 1, 0, 9,  1, 32'h0B);
        vecs[6]  = mk(0, 0, 0, 1, 32'h00, 0,  0, 9,  0, 1, 0, 0, 0,  0, 32'h0B);
        vecs[7]  = mk(0, 0, 1, 0, 32'h21, 7,  2, 7,  1, 1, 1, 0, 7,  2, 32'h21);
        vecs[8]  = mk(0, 0, 0, 1, 32'h00, 0,  0, 7,  0, 1, 0, 0, 0,  0, 32'h21);
        vecs[9]  = mk(0, 0, 1, 0, 32'h22, 0,  1, 0,  1, 1, 1, 0, 0,  1, 32'h22);
        vecs[10] = mk(0, 0, 1, 0, 32'h23, 5,  3, 0,  1, 0, 2, 0, 0,  1, 32'h22);
        vecs[11] = mk(0, 1, 1, 0, 32'h0C, 6,  1, 6,  0, 1, 0, 0, 0,  0, 32'h22);
        vecs[12] = mk(0, 0, 0, 1, 32'h00, 0,  0, 6,  0, 1, 0, 0, 0,  0, 32'h22);
        vecs[13] = mk(0, 0, 1, 0, 32'h31, 2,  1, 2,  1, 1, 1, 1, 2,  1, 32'h31);
        vecs[14] = mk(0, 0, 1, 0, 32'h32, 3,  1, 2,  1, 0, 2, 1, 2,  1, 32'h31);
        vecs[15] = mk(1, 0, 0, 0, 32'h00, 0,  0, 2,  0, 1, 0, 0, 0,  0, 32'h0);
        vecs[16] = mk(0, 0, 1, 0, 32'h41, 1,  1, 1,  1, 1, 1, 1, 1,  1, 32'h41);
        vecs[17] = mk(0, 1, 1, 1, 32'h42, 1,  1, 1,  0, 1, 0, 0, 0,  0, 32'h41);
        vecs[18] = mk(0, 0, 1, 1, 32'h51, 8,  1, 8,  1, 1, 1, 1, 8,  1, 32'h51);
        vecs[19] = mk(0, 0, 1, 1, 32'h52, 10, 0, 8,  1, 1, 1, 0, 10, 0, 32'h52);
        vecs[20] = mk(0, 0, 0, 1, 32'h00, 0,  0, 8,  0, 1, 0, 0, 0,  0, 32'h52);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, d1.valid}, 32'd0);
        chk("reset_in_ready", {31'd0, u1.ready}, 32'd1);
        chk("reset_occupancy", {30'd0, occ1}, {30'd0, OCC_EMPTY});
        chk("reset_out_payload", d1.payload, 32'd0);
        chk("reset0_in_ready", {31'd0, u0.ready}, 32'd1);

        for (int i = 0; i < NV; i++) apply(i, vecs[i]);
        reset = 1'b0;
        flush = 1'b0;

        emit_base = n_emit;
        for (int i = 0; i < 16; i++) begin
            u1.valid   = 1'b1;
            u1.payload = 32'h10 + i;
            u1.dest    = 5'(i + 1);
            u1.ctrl    = 2'b01;
            d1.ready   = 1'b1;
            #1;
            chk($sformatf("stream%0d_in_ready", i), {31'd0, u1.ready}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_out_valid", i), {31'd0, d1.valid}, 32'd1);
            chk($sformatf("stream%0d_payload", i), d1.payload, 32'h10 + i);
            chk($sformatf("stream%0d_dest", i), {27'd0, d1.dest}, i + 1);
        end
        u1.valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_drained", {31'd0, d1.valid}, 32'd0);
        chk("stream_emit_count", n_emit - emit_base, 32'd16);

        u0.valid = 1'b1; u0.payload = 32'h61; u0.dest = 5'd4; u0.ctrl = 2'b01;
        d0.ready = 1'b0;
        fwd_src  = 5'd4;
        @(posedge clk);
        #1;
        chk("s0_out_valid", {31'd0, d0.valid}, 32'd1);
        chk("s0_occupancy", {30'd0, occ0}, {30'd0, OCC_ONE});
        chk("s0_payload", d0.payload, 32'h61);
        chk("s0_fwd_hit", {31'd0, fwd_hit0}, 32'd1);
        u0.payload = 32'h62; u0.dest = 5'd5;
        #1;
        chk("s0_stall_in_ready", {31'd0, u0.ready}, 32'd0);
        d0.ready = 1'b1;
        #1;
        chk("s0_comb_in_ready", {31'd0, u0.ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("s0_replace_payload", d0.payload, 32'h62);
        chk("s0_replace_dest", {27'd0, d0.dest}, 32'd5);
        chk("s0_replace_occ", {30'd0, occ0}, {30'd0, OCC_ONE});
        u0.valid = 1'b0;
        @(posedge clk);
        #1;
        chk("s0_empty_valid", {31'd0, d0.valid}, 32'd0);
        chk("s0_empty_dest", {27'd0, d0.dest}, 32'd0);
        chk("s0_empty_occ", {30'd0, occ0}, {30'd0, OCC_EMPTY});

        chk("sb_leftover", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline-stage register; successor to the fixed MEM/WB latch.
- Carries payload, destination register index and control bits between stages under valid/ready flow control.
- Optional skid buffer gives a registered in_ready; provides flush (bubble insert) and a forwarding-hit compare for hazard logic.
- Instantiated between every pair of pipeline stages (IF/ID ... MEM/WB).

Parameters:
DATA_W, 32, payload width (ALU result / memory data, concatenated by the instantiator)
REG_W, 5, destination register index width
CTRL_W, 2, control-bit width; bit 0 is RegWrite by definition
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational ready

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  discard all held entries (bubble)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage accepts an entry this cycle
in_payload  in  DATA_W  upstream payload
in_dest  in  REG_W  upstream destination register
in_ctrl  in  CTRL_W  upstream control bits
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head entry
out_payload  out  DATA_W  head payload
out_dest  out  REG_W  head destination (0 when invalid)
out_ctrl  out  CTRL_W  head control (0 when invalid)
fwd_src  in  REG_W  source register queried by hazard unit
fwd_hit  out  1  head entry will write fwd_src
occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Accept = in_valid & in_ready; Emit = out_valid & out_ready; both evaluated at posedge clk.
- Reset (sync, priority over everything): main/skid valid = 0; out_payload, out_dest, out_ctrl = 0; occupancy = 0; in_ready = 1 from the first cycle after reset.
- Invalid entries always present out_dest = 0 and out_ctrl = 0 (RegWrite never leaks from a bubble); out_payload holds its last value.
- SKID=1 states: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
  - EMPTY: Accept -> ONE, entry in main.
  - ONE: Accept & Emit -> ONE, main replaced; Accept only -> FULL, entry in skid; Emit only -> EMPTY.
  - FULL: in_ready = 0; Emit -> ONE, skid moves to main.
  - in_ready = !skid_valid, a registered value; no combinational path from out_ready to in_ready.
- SKID=0: single main register; in_ready = !out_valid | out_ready (combinational); Accept & Emit same cycle -> main replaced.
- Latency: in to out = 1 cycle when empty; throughput 1 entry/cycle when out_ready is held high.
- Ordering: strict FIFO; skid entry never overtakes main.
- flush (priority below reset, above everything else): next cycle all valid = 0, occupancy = 0. Any Accept in the flush cycle is dropped. An Emit in the flush cycle still counts as taken by downstream. in_ready = 1 the following cycle.
- Stall: out_ready = 0 holds all outputs stable; a full stage holds in_ready = 0.
- fwd_hit = out_valid & out_ctrl[0] & (out_dest == fwd_src) & (fwd_src != 0); purely combinational from registered state. Queries only the head entry; the skid entry is younger and is excluded.
- occupancy = main_valid + skid_valid, registered.

Decomposition:
- Shared package pipe_pkg: default widths (XLEN=32, REG_W=5), control-bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1), occupancy encoding.
- One natural sub-module: pipe_skid_entry (valid + payload/dest/ctrl register with load/clear). Instantiated twice for SKID=1 and once for SKID=0.

Test Plan:
- Reset mid-stream: fill to FULL, assert reset one cycle -> next cycle out_valid=0, out_ctrl=0, out_dest=0, occupancy=0, in_ready=1.
- Streaming, out_ready=1: push payload 0x10..0x1F, dest 1..16 back-to-back -> identical sequence out, one cycle later, no gaps, in_ready never drops.
- Backpressure: out_ready=0, push 0xA, 0xB -> occupancy=2, in_ready=0, out_payload=0xA stable. Release out_ready -> 0xA then 0xB emitted in order, in_ready=1 after first Emit.
- Flush with concurrent input: FULL stage, flush=1 with in_valid=1 and payload 0xC -> next cycle occupancy=0, out_valid=0; 0xC never appears at out.
- Forwarding: head dest=7, ctrl=2'b01, out_ready=0. fwd_src=7 -> fwd_hit=1. fwd_src=0 (dest 0) -> fwd_hit=0. ctrl=2'b10 -> fwd_hit=0. Entry present only in skid -> fwd_hit=0.
- SKID=0 build: out_ready=0 with one entry held -> in_ready=0 combinationally. Set out_ready=1 in the same cycle -> in_ready=1 and the new entry is accepted as the old one is emitted.
